// File: rtl/writeback_regfile_pkg.sv
// cpu_pkg: constants shared by the writeback stage and register file.
//   REG_ADDR_W  : register index width
//   NUM_REGS    : architectural register count
//   ZERO_REG    : index of the hardwired-zero register
//   DATA_W      : datapath width
//   UPPER_SHIFT : left shift applied by the upper-immediate writeback form
package cpu_pkg;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned UPPER_SHIFT = 16;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
endpackage

// File: rtl/writeback_regfile_wb_result_mux.sv
// wb_result_mux: combinational writeback value selection.
//   mem_to_reg : 1 selects read_data, 0 selects alu_result
//   upper      : 1 moves the low half of the selection into the upper half
//   alu_result : ALU result input
//   read_data  : load data input
//   result     : final writeback value
module wb_result_mux #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              mem_to_reg,
  input  logic              upper,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] result
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] sel;

  always_comb begin
    sel    = mem_to_reg ? read_data : alu_result;
    // Shifting left by the half-width drops the upper half of sel and
    // zero-fills the lower half, i.e. {sel[15:0], 16'h0} at 32 bits.
    result = upper ? (sel << UPPER_SHIFT) : sel;
  end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback stage plus architectural register file.
// Optional feature macro: WB_BYPASS_EN (write-through bypass to read ports).
//   clk, rst_n          : clock, async active-low reset (clears all registers)
//   reg_write_w         : commit enable
//   mem_to_reg_w        : select load data (1) or ALU result (0)
//   alu_result_w        : ALU result
//   read_data_w         : load data
//   write_reg_w         : destination index
//   upper_w             : upper-immediate form
//   read_reg1_d/2_d     : decode-stage source indices
//   read_data1_d/2_d    : combinational source values
//   result_w            : writeback value for forwarding
module writeback_regfile #(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_w,
  input  logic              mem_to_reg_w,
  input  logic [DATA_W-1:0] alu_result_w,
  input  logic [DATA_W-1:0] read_data_w,
  input  logic [AW-1:0]     write_reg_w,
  input  logic              upper_w,
  input  logic [AW-1:0]     read_reg1_d,
  input  logic [AW-1:0]     read_reg2_d,
  output logic [DATA_W-1:0] read_data1_d,
  output logic [DATA_W-1:0] read_data2_d,
  output logic [DATA_W-1:0] result_w
);
  import cpu_pkg::*;

  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;

  wb_result_mux #(
    .DATA_W(DATA_W)
  ) u_mux (
    .mem_to_reg (mem_to_reg_w),
    .upper      (upper_w),
    .alu_result (alu_result_w),
    .read_data  (read_data_w),
    .result     (result_w)
  );

  assign commit = reg_write_w && (write_reg_w != ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[write_reg_w] <= result_w;
    end
  end

  // Register 0 is forced to zero here as well so the bypass can never
  // leak a discarded write onto a read of it.
  always_comb begin
    read_data1_d = '0;
    read_data2_d = '0;
    if (read_reg1_d != ZERO) begin
      read_data1_d = regs[read_reg1_d];
`ifdef WB_BYPASS_EN
      if (commit && (read_reg1_d == write_reg_w)) begin
        read_data1_d = result_w;
      end
`endif
    end
    if (read_reg2_d != ZERO) begin
      read_data2_d = regs[read_reg2_d];
`ifdef WB_BYPASS_EN
      if (commit && (read_reg2_d == write_reg_w)) begin
        read_data2_d = result_w;
      end
`endif
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;
  logic        clk;
  logic        rst_n;
  logic        reg_write_w;
  logic        mem_to_reg_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [4:0]  write_reg_w;
  logic        upper_w;
  logic [4:0]  read_reg1_d;
  logic [4:0]  read_reg2_d;
  logic [31:0] read_data1_d;
  logic [31:0] read_data2_d;
  logic [31:0] result_w;

  writeback_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_w (mem_to_reg_w),
    .alu_result_w (alu_result_w),
    .read_data_w  (read_data_w),
    .write_reg_w  (write_reg_w),
    .upper_w      (upper_w),
    .read_reg1_d  (read_reg1_d),
    .read_reg2_d  (read_reg2_d),
    .read_data1_d (read_data1_d),
    .read_data2_d (read_data2_d),
    .result_w     (result_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] res;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wb_value(input logic m2r, input logic up,
                                           input logic [31:0] alu, input logic [31:0] ld);
    logic [31:0] s;
    s = m2r ? ld : alu;
    return up ? {s[15:0], 16'h0000} : s;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wr, input logic [31:0] res);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && wr != 5'd0 && a == wr) return res;
`endif
    return model[a];
  endfunction

  // Issue one cycle of stimulus starting at posedge+1; returns at next posedge+1.
  task automatic drive(input string tag, input logic we, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] wr, input logic up,
                       input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    logic [31:0] res;
    reg_write_w  = we;
    mem_to_reg_w = m2r;
    alu_result_w = alu;
    read_data_w  = ld;
    write_reg_w  = wr;
    upper_w      = up;
    read_reg1_d  = a1;
    read_reg2_d  = a2;
    res   = wb_value(m2r, up, alu, ld);
    e.r1  = ref_read(a1, we, wr, res);
    e.r2  = ref_read(a2, we, wr, res);
    e.res = res;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    if (rst_n && we && wr != 5'd0) model[wr] = res;
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; checked before any clock edge.
  task automatic mid_cycle_reset(input logic [4:0] a);
    reg_write_w  = 1'b0;
    mem_to_reg_w = 1'b0;
    upper_w      = 1'b1;
    alu_result_w = 32'h0000_4321;
    read_reg1_d  = a;
    read_reg2_d  = a;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    chk("reset_rd1", read_data1_d, 32'h0);
    chk("reset_rd2", read_data2_d, 32'h0);
    chk("reset_result_follows", result_w, 32'h4321_0000);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_rd1"}, read_data1_d, e.r1);
        chk({e.tag, "_rd2"}, read_data2_d, e.r2);
        chk({e.tag, "_result"}, result_w, e.res);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    reg_write_w = 0; mem_to_reg_w = 0; upper_w = 0;
    alu_result_w = 0; read_data_w = 0; write_reg_w = 0;
    read_reg1_d = 0; read_reg2_d = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    drive("post_reset", 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd5, 5'd31);
    // Preload r5, then reset mid-cycle.
    drive("preload_r5", 1, 0, 32'hDEADBEEF, 32'h0, 5'd5, 0, 5'd5, 5'd0);
    drive("read_r5",    0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd5, 5'd5);
    mid_cycle_reset(5'd5);
    drive("r5_after_reset", 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd5, 5'd5);
    // ALU, load, upper writebacks.
    drive("alu_r7",   1, 0, 32'h12345678, 32'h0, 5'd7, 0, 5'd7, 5'd1);
    drive("load_r9",  1, 1, 32'h0BADBAD0, 32'hCAFEF00D, 5'd9, 0, 5'd7, 5'd9);
    drive("upper_r10",1, 0, 32'h0000ABCD, 32'h0, 5'd10, 1, 5'd9, 5'd10);
    drive("upper_ld", 1, 1, 32'h0, 32'h1234BEEF, 5'd11, 1, 5'd10, 5'd11);
    drive("read_back",0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd10, 5'd11);
    // Zero register.
    drive("r0_write", 1, 0, 32'hFFFFFFFF, 32'h0, 5'd0, 0, 5'd0, 5'd0);
    drive("r0_after", 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd0, 5'd0);
    drive("r0_others",0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd7, 5'd9);
    // Same-cycle read of the written register.
    drive("r3_init",  1, 0, 32'h11, 32'h0, 5'd3, 0, 5'd0, 5'd0);
    drive("r3_same",  1, 0, 32'h22, 32'h0, 5'd3, 0, 5'd3, 5'd3);
    drive("r3_after", 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd3, 5'd3);
    // Disabled write.
    drive("r4_disabled", 0, 0, 32'h55, 32'h0, 5'd4, 0, 5'd4, 5'd4);
    drive("r4_after",    0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd4, 5'd3);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      logic [4:0] a1;
      logic [4:0] a2;
      wr = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) mid_cycle_reset(a1);
      drive("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom, $urandom, wr, 1'($urandom_range(0, 3) == 0), a1, a2);
    end

    @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
